// File: rtl/rt_clock.sv
// Free-running seconds/nanoseconds timebase with fractional trim, PPS period
// measurement and an AXI4-Lite register block.
module rt_clock #(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 32,
   parameter logic [31:0] C_BASEADDR         = 32'h0000_0000,
   parameter int          C_CLK_TO_NS_RATIO  = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   output logic [47:0]                     sec,
   output logic [29:0]                     nsec,
   input  logic                            pps,
   input  logic                            pps2,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY
);

   localparam logic [31:0] RATIO      = 32'(C_CLK_TO_NS_RATIO);
   localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

   logic [47:0] sec_q, sec_d;
   logic [29:0] nsec_q, nsec_d;
   logic [31:0] frac_q, frac_d;
   logic        ctrl_sel_q, ctrl_sel_d, load_q, load_d, ctrl_apply_q, ctrl_apply_d;
   logic [15:0] cfg_hi_q, cfg_hi_d;
   logic [31:0] cfg_lo_q, cfg_lo_d, delta_q, delta_d, snap_q, snap_d;
   logic        sel_act_q, sel_act_d;
   logic        sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
   logic [31:0] acc_q, acc_d, last_q, last_d;
   logic        awready_q, awready_d, bvalid_q, bvalid_d;
   logic        arready_q, arready_d, rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;

   logic [33:0] sum34;
   logic [31:0] inc, nsec_sum, acc_sat, rd_value;
   logic [32:0] acc_sum;
   logic        wr_fire, wr_hit, rd_fire, rd_hit, pps_pin;
   logic [7:0]  wr_off, rd_off;
   logic        unused_wstrb;

   assign unused_wstrb = ^S_AXI_WSTRB;

   // Valid/ready: a channel transfers on the edge where both are high; the
   // slave raises AWREADY/WREADY or ARREADY for exactly one cycle and holds
   // BVALID/RVALID until the master's BREADY/RREADY completes the response.
   assign wr_fire = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
   assign wr_hit  = (S_AXI_AWADDR[31:8] == C_BASEADDR[31:8]);
   assign wr_off  = S_AXI_AWADDR[7:0];
   assign rd_fire = arready_q && S_AXI_ARVALID;
   assign rd_hit  = (S_AXI_ARADDR[31:8] == C_BASEADDR[31:8]);
   assign rd_off  = S_AXI_ARADDR[7:0];

   always_comb begin
      // Fractional trim: the carry/borrow out of the 32-bit fraction nudges inc by +/-1
      sum34    = {2'b00, frac_q} + {{2{delta_q[31]}}, delta_q};
      inc      = RATIO + {{30{sum34[33]}}, sum34[33:32]};
      nsec_sum = {2'b00, nsec_q} + inc;
      acc_sum  = {1'b0, acc_q} + {1'b0, inc};
      acc_sat  = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];

      sec_d  = sec_q;
      nsec_d = nsec_q;
      frac_d = frac_q;
      if (load_q) begin
         sec_d  = {cfg_hi_q, cfg_lo_q};
         nsec_d = 30'd0;
         frac_d = 32'd0;
      end else begin
         frac_d = sum34[31:0];
         if (nsec_sum >= NS_PER_SEC) begin
            nsec_d = 30'(nsec_sum - NS_PER_SEC);
            sec_d  = sec_q + 48'd1;
         end else begin
            nsec_d = nsec_sum[29:0];
         end
      end

      pps_pin   = sel_act_q ? pps2 : pps;
      sync1_d   = pps_pin;
      sync2_d   = sync1_q;
      sync3_d   = sync2_q;
      acc_d     = acc_sat;
      last_d    = last_q;
      sel_act_d = ctrl_apply_q ? ctrl_sel_q : sel_act_q;
      if (ctrl_apply_q && (ctrl_sel_q != sel_act_q)) begin
         sync1_d = 1'b0;
         sync2_d = 1'b0;
         sync3_d = 1'b0;
         acc_d   = 32'd0;
      end else if (sync2_q && !sync3_q) begin
         last_d = acc_sat;
         acc_d  = 32'd0;
      end

      ctrl_sel_d   = ctrl_sel_q;
      load_d       = 1'b0;
      ctrl_apply_d = 1'b0;
      cfg_hi_d     = cfg_hi_q;
      cfg_lo_d     = cfg_lo_q;
      delta_d      = delta_q;
      if (wr_fire && wr_hit) begin
         case (wr_off)
            8'h00: begin
               ctrl_sel_d   = S_AXI_WDATA[1];
               load_d       = S_AXI_WDATA[0];
               ctrl_apply_d = 1'b1;
            end
            8'h08:   cfg_hi_d = S_AXI_WDATA[15:0];
            8'h0C:   cfg_lo_d = S_AXI_WDATA;
            8'h20:   delta_d  = S_AXI_WDATA;
            default: ;
         endcase
      end

      rd_value = 32'd0;
      if (rd_hit) begin
         case (rd_off)
            8'h00:   rd_value = {30'd0, ctrl_sel_q, 1'b0};
            8'h08:   rd_value = {16'd0, cfg_hi_q};
            8'h0C:   rd_value = cfg_lo_q;
            8'h10:   rd_value = {16'd0, sec_q[47:32]};
            8'h14:   rd_value = snap_q;
            8'h18:   rd_value = {2'b00, nsec_q};
            8'h1C:   rd_value = last_q;
            8'h20:   rd_value = delta_q;
            default: rd_value = 32'd0;
         endcase
      end
      snap_d = snap_q;
      if (rd_fire && rd_hit && (rd_off == 8'h10)) snap_d = sec_q[31:0];

      awready_d = S_AXI_AWVALID && S_AXI_WVALID && !awready_q && !bvalid_q;
      bvalid_d  = bvalid_q;
      if (wr_fire)                        bvalid_d = 1'b1;
      else if (bvalid_q && S_AXI_BREADY)  bvalid_d = 1'b0;
      arready_d = S_AXI_ARVALID && !rvalid_q && !arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      if (rd_fire) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_value;
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sec_q        <= 48'd0;
         nsec_q       <= 30'd0;
         frac_q       <= 32'd0;
         ctrl_sel_q   <= 1'b0;
         load_q       <= 1'b0;
         ctrl_apply_q <= 1'b0;
         cfg_hi_q     <= 16'd0;
         cfg_lo_q     <= 32'd0;
         delta_q      <= 32'd0;
         snap_q       <= 32'd0;
         sel_act_q    <= 1'b0;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         sync3_q      <= 1'b0;
         acc_q        <= 32'd0;
         last_q       <= 32'd0;
         awready_q    <= 1'b0;
         bvalid_q     <= 1'b0;
         arready_q    <= 1'b0;
         rvalid_q     <= 1'b0;
         rdata_q      <= 32'd0;
      end else begin
         sec_q        <= sec_d;
         nsec_q       <= nsec_d;
         frac_q       <= frac_d;
         ctrl_sel_q   <= ctrl_sel_d;
         load_q       <= load_d;
         ctrl_apply_q <= ctrl_apply_d;
         cfg_hi_q     <= cfg_hi_d;
         cfg_lo_q     <= cfg_lo_d;
         delta_q      <= delta_d;
         snap_q       <= snap_d;
         sel_act_q    <= sel_act_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         sync3_q      <= sync3_d;
         acc_q        <= acc_d;
         last_q       <= last_d;
         awready_q    <= awready_d;
         bvalid_q     <= bvalid_d;
         arready_q    <= arready_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
      end
   end

   assign sec           = sec_q;
   assign nsec          = nsec_q;
   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RVALID  = rvalid_q;

endmodule

// File: tb/tb_rt_clock.sv
// Directed bench for rt_clock: AXI reads are scoreboarded, timebase outputs
// are checked at fixed cycle offsets. A second instance with a large ratio covers rollover.
module tb_rt_clock;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pps = 1'b0;
   logic        pps2 = 1'b0;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic [3:0]  wstrb = 4'hF;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;

   logic [47:0] sec, w_sec;
   logic [29:0] nsec, w_nsec;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic        w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
   logic [1:0]  w_bresp, w_rresp;
   logic [31:0] w_rdata;

   logic [63:0] exp_q[$];
   string       name_q[$];
   int          n_checks = 0;
   int          n_fail = 0;

   rt_clock #(.C_CLK_TO_NS_RATIO(8)) dut (
      .clk(clk), .rst(rst), .sec(sec), .nsec(nsec), .pps(pps), .pps2(pps2),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
   );

   // Same bus stimulus; 250 ms per cycle makes a second roll over every 4 cycles.
   rt_clock #(.C_CLK_TO_NS_RATIO(250_000_000)) dut_wrap (
      .clk(clk), .rst(rst), .sec(w_sec), .nsec(w_nsec), .pps(pps), .pps2(pps2),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(w_awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(w_wready),
      .S_AXI_BRESP(w_bresp), .S_AXI_BVALID(w_bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(w_arready),
      .S_AXI_RDATA(w_rdata), .S_AXI_RRESP(w_rresp), .S_AXI_RVALID(w_rvalid), .S_AXI_RREADY(rready)
   );

   // Clock / reset / PPS sources
   always #5 clk = ~clk;

   initial begin
      #3;
      forever begin
         pps = 1'b1; #30;
         pps = 1'b0; #40;
      end
   end

   initial begin
      #7;
      forever begin
         pps2 = 1'b1; #50;
         pps2 = 1'b0; #50;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: each read response is compared against the head of exp_q
   always @(negedge clk) begin
      logic [63:0] e;
      string       nm;
      if (rvalid && rready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_unexpected: got 0x%08h, required no response", rdata);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (rdata < e[31:0] || rdata > e[63:32]) begin
               n_fail++;
               $display("FAIL %s: got 0x%08h (%0d), required %0d..%0d", nm, rdata, rdata, e[31:0], e[63:32]);
            end
            n_checks++;
            if (rresp !== 2'b00) begin
               n_fail++;
               $display("FAIL %s_rresp: got %0d, required 0", nm, rresp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Driver tasks; both return 1 ns after the edge following the response
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
      int cyc;
      awaddr  = addr;
      wdata   = data;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      cyc     = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!awready && cyc < 50);
      if (!awready) begin
         awvalid = 1'b0;
         wvalid  = 1'b0;
         chk("wr_awready_timeout", 64'(awready), 64'd1);
         return;
      end
      @(posedge clk); #1;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      chk("wr_bvalid", 64'(bvalid), 64'd1);
      chk("wr_bresp", 64'(bresp), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [31:0] lo, input logic [31:0] hi,
                           input string name);
      int cyc;
      exp_q.push_back({hi, lo});
      name_q.push_back(name);
      araddr  = addr;
      arvalid = 1'b1;
      cyc     = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!arready && cyc < 50);
      if (!arready) begin
         arvalid = 1'b0;
         void'(exp_q.pop_back());
         void'(name_q.pop_back());
         chk("rd_arready_timeout", 64'(arready), 64'd1);
         return;
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic rd_exact(input logic [31:0] addr, input logic [31:0] val, input string name);
      axi_read(addr, val, val, name);
   endtask

   initial begin
      logic [29:0] t0;
      int          cyc;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_sec", 64'(sec), 64'd0);
      chk("reset_nsec", 64'(nsec), 64'd0);
      chk("reset_awready", 64'(awready), 64'd0);
      chk("reset_rvalid", 64'(rvalid), 64'd0);
      rst = 1'b0;

      // Free run: 100 increments of 8 ns
      repeat (100) @(posedge clk);
      #1;
      chk("run100_nsec", 64'(nsec), 64'd800);
      chk("run100_sec", 64'(sec), 64'd0);
      chk("run100_wrap_sec", 64'(w_sec), 64'd25);
      chk("run100_wrap_nsec", 64'(w_nsec), 64'd0);

      // Mid-run reset
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midreset_sec", 64'(sec), 64'd0);
      chk("midreset_nsec", 64'(nsec), 64'd0);
      rst = 1'b0;

      // PPS source 0 selected after reset: 7-cycle period
      rd_exact(32'h00, 32'd0, "control_after_reset");
      repeat (30) @(posedge clk);
      #1;
      rd_exact(32'h1C, 32'd56, "last_period_pps0");

      // Load sec = 10 and switch to pps2
      axi_write(32'h08, 32'd0);
      axi_write(32'h0C, 32'd10);
      axi_write(32'h00, 32'd3);
      chk("load_sec", 64'(sec), 64'd10);
      chk("load_nsec", 64'(nsec), 64'd0);
      rd_exact(32'h00, 32'd2, "control_readback");
      rd_exact(32'h10, 32'd0, "sec_state_hi");
      rd_exact(32'h14, 32'd10, "sec_state_lo");
      rd_exact(32'h0C, 32'd10, "sec_config_lo");

      // pps2 at 10 cycles
      repeat (40) @(posedge clk);
      #1;
      rd_exact(32'h1C, 32'd80, "last_period_pps2_a");
      repeat (13) @(posedge clk);
      #1;
      rd_exact(32'h1C, 32'd80, "last_period_pps2_b");

      // Negative trim: -15/32 ns per cycle, exactly 150 ns lost over 320 cycles
      axi_write(32'h20, 32'h8800_0000);
      t0 = nsec;
      repeat (320) @(posedge clk);
      #1;
      chk("trim_neg_320cyc", 64'(nsec - t0), 64'd2410);
      rd_exact(32'h20, 32'h8800_0000, "delta_readback");
      for (int i = 0; i < 3; i++) begin
         axi_read(32'h1C, 32'd75, 32'd76, "last_period_trim_neg");
         repeat (7) @(posedge clk);
         #1;
      end

      // Positive trim: +15/32 ns per cycle
      axi_write(32'h20, 32'h7800_0000);
      t0 = nsec;
      repeat (320) @(posedge clk);
      #1;
      chk("trim_pos_320cyc", 64'(nsec - t0), 64'd2710);
      for (int i = 0; i < 3; i++) begin
         axi_read(32'h1C, 32'd84, 32'd85, "last_period_trim_pos");
         repeat (7) @(posedge clk);
         #1;
      end

      // Load the last second; the large-ratio instance rolls both counters over
      axi_write(32'h20, 32'd0);
      axi_write(32'h08, 32'h1234_FFFF);
      axi_write(32'h0C, 32'hFFFF_FFFF);
      axi_write(32'h00, 32'd3);
      chk("max_load_sec", 64'(sec), 64'hFFFF_FFFF_FFFF);
      chk("max_load_wrap_nsec", 64'(w_nsec), 64'd0);
      chk("max_load_wrap_sec", 64'(w_sec), 64'hFFFF_FFFF_FFFF);
      repeat (3) @(posedge clk);
      #1;
      chk("near_wrap_nsec", 64'(w_nsec), 64'd750_000_000);
      chk("near_wrap_sec", 64'(w_sec), 64'hFFFF_FFFF_FFFF);
      @(posedge clk); #1;
      chk("wrap_nsec", 64'(w_nsec), 64'd0);
      chk("wrap_sec", 64'(w_sec), 64'd0);
      chk("nowrap_nsec", 64'(nsec), 64'd32);
      rd_exact(32'h08, 32'h0000_FFFF, "sec_config_hi_16bit");
      rd_exact(32'h10, 32'h0000_FFFF, "sec_state_hi_max");
      rd_exact(32'h14, 32'hFFFF_FFFF, "sec_state_lo_max");

      // Decode: foreign block, unmapped offsets
      axi_write(32'h0000_0120, 32'd5);
      rd_exact(32'h20, 32'd0, "foreign_write_ignored");
      rd_exact(32'h0000_0120, 32'd0, "foreign_read_zero");
      axi_write(32'h04, 32'hFFFF_FFFF);
      rd_exact(32'h04, 32'd0, "unmapped_read_04");
      rd_exact(32'h24, 32'd0, "unmapped_read_24");
      rd_exact(32'h00, 32'd2, "control_after_unmapped_write");

      cyc = 0;
      while (exp_q.size() != 0 && cyc < 20) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
